memory_latency_vcomp: RTL

MEMORY_LATENCY_VCOMP -- requirements
Module: memory_latency_vcomp

---
 rtl/memory_latency_vcomp_pkg.sv | 20 ++
 rtl/memory_latency_vcomp_check.sv | 29 ++
 rtl/memory_latency_vcomp.sv | 124 ++++++++++++
 3 files changed

// File: rtl/memory_latency_vcomp_pkg.sv
// Access-width type shared by the latency memory model and its address checker.
package memory_access_width;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } memory_access_width_t;

  function automatic logic [3:0] memory_access_width_to_bytes(memory_access_width_t w);
    case (w)
      BYTE:    return 4'd1;
      HALF:    return 4'd2;
      WORD:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/memory_latency_vcomp_check.sv
// Combinational legality check of one access: alignment, range and bus-width support.
module memory_access_check
  import memory_access_width::*;
#(
  parameter int BYTES      = 65536,
  parameter int DATA_WIDTH = 32,
  localparam int AW        = $clog2(BYTES)
) (
  input  logic [AW-1:0]         addr,
  input  memory_access_width_t  width,
  output logic                  error,
  output logic [3:0]            nbytes
);

  logic [AW:0] end_addr;
  logic        misaligned;
  logic        out_of_range;
  logic        unsupported;

  always_comb begin
    nbytes       = memory_access_width_to_bytes(width);
    end_addr     = {1'b0, addr} + (AW+1)'(nbytes);
    misaligned   = (addr & AW'(nbytes - 4'd1)) != '0;
    out_of_range = end_addr > (AW+1)'(BYTES);
    unsupported  = (width == DOUBLE) && (DATA_WIDTH == 32);
    error        = misaligned || out_of_range || unsupported;
  end

endmodule

// File: rtl/memory_latency_vcomp.sv
// Byte-addressed memory with a fixed request-to-response latency and a
// single outstanding transaction; one idle bubble follows every response.
module memory_latency_vcomp
  import memory_access_width::*;
#(
  parameter int         BYTES      = 65536,
  parameter int         DATA_WIDTH = 32,
  parameter int         LATENCY    = 2,
  parameter logic [7:0] FILL_BYTE  = 8'h00,
  localparam int        AW         = $clog2(BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  memory_access_width_t  req_width,
  input  logic [AW-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  bubble_q, bubble_d;
  logic                  accept;
  logic                  acc_error;
  logic [3:0]            acc_bytes;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  error_q;
  logic [7:0]            mem [BYTES];

  memory_access_check #(.BYTES(BYTES), .DATA_WIDTH(DATA_WIDTH)) u_check (
    .addr   (req_addr),
    .width  (req_width),
    .error  (acc_error),
    .nbytes (acc_bytes)
  );

  // Pre-write contents of the addressed bytes; lanes above the access size stay zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LANES; i++)
      if (i < int'(acc_bytes))
        rd_data[8*i +: 8] = mem[AW'(int'(req_addr) + i)];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bubble_d  = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !bubble_q;
        if (req_valid && !bubble_q) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d  = IDLE;
          bubble_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bubble_q <= 1'b0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bubble_q <= bubble_d;
      if (accept) begin
        error_q <= acc_error;
        rdata_q <= (acc_error || req_write) ? '0 : rd_data;
      end
    end
  end

  // Reset fill wins over a request presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BYTES; i++) mem[i] <= FILL_BYTE;
    end else if (accept && req_write && !acc_error) begin
      for (int i = 0; i < LANES; i++)
        if (i < int'(acc_bytes))
          mem[AW'(int'(req_addr) + i)] <= req_wdata[8*i +: 8];
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule
